wm_cycle_sequencer: RTL and testbench

WM_CYCLE_SEQUENCER -- requirements
Module: wm_cycle_sequencer

---
 rtl/wm_pkg.sv | 35 +++
 rtl/wm_phase_timer.sv | 29 ++
 rtl/wm_cycle_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_wm_cycle_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared state encoding and program-select constants for the washing-machine sequencer.
package wm_pkg;

  typedef logic [2:0] wm_state_t;

  localparam wm_state_t ST_IDLE  = 3'd0;
  localparam wm_state_t ST_READY = 3'd1;
  localparam wm_state_t ST_SOAK  = 3'd2;
  localparam wm_state_t ST_WASH  = 3'd3;
  localparam wm_state_t ST_RINSE = 3'd4;
  localparam wm_state_t ST_SPIN  = 3'd5;

  localparam logic [1:0] PROG_NONE  = 2'd0;
  localparam logic [1:0] PROG_FULL  = 2'd1;
  localparam logic [1:0] PROG_WASH  = 2'd2;
  localparam logic [1:0] PROG_RINSE = 2'd3;

  // mode_1 outranks mode_2, which outranks mode_3
  function automatic logic [1:0] prog_select(input logic m1, input logic m2, input logic m3);
    if (m1) begin
      return PROG_FULL;
    end else if (m2) begin
      return PROG_WASH;
    end else if (m3) begin
      return PROG_RINSE;
    end else begin
      return PROG_NONE;
    end
  endfunction

  function automatic logic is_running(input wm_state_t s);
    return (s >= ST_SOAK) && (s <= ST_SPIN);
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Loadable down-counter that times one wash phase; holds at zero and while disabled.
module wm_phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load has priority over counting; a disabled or expired counter holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != {CNT_W{1'b0}})) begin
      count <= count - CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/wm_cycle_sequencer.sv
// Coin-operated washing-machine cycle sequencer with lid interlock, cancel and refund.
module wm_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SOAK_CYC   = 1000,
  parameter int unsigned WASH_CYC   = 2000,
  parameter int unsigned RINSE_CYC  = 1000,
  parameter int unsigned SPIN_CYC   = 500,
  parameter int unsigned FILL_CYC   = 100,
  parameter int unsigned COIN_PRICE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lid,
  input  logic             coin,
  input  logic             cancel,
  input  logic             mode_1,
  input  logic             mode_2,
  input  logic             mode_3,
  output logic             idle,
  output logic             ready,
  output logic             soak_Operation,
  output logic             wash_Operation,
  output logic             rinse_Operation,
  output logic             spin_Operation,
  output logic             water_Intake,
  output logic             coin_Return,
  output logic             paused,
  output logic             done,
  output logic [CNT_W-1:0] time_left
);

  localparam logic [3:0] PRICE_C = 4'(COIN_PRICE);

  wm_state_t        state_r, state_s;
  logic [3:0]       credit_r, credit_s;
  logic [1:0]       prog_s;
  logic             tmr_load_s, tmr_en_s, tmr_zero_s;
  logic [CNT_W-1:0] tmr_val_s, tmr_cnt_s, cnt_next_s;
  logic             coin_ret_s, done_s, water_s, run_next_s;

  function automatic logic [CNT_W-1:0] phase_len(input wm_state_t s);
    case (s)
      ST_SOAK:  phase_len = CNT_W'(SOAK_CYC);
      ST_WASH:  phase_len = CNT_W'(WASH_CYC);
      ST_RINSE: phase_len = CNT_W'(RINSE_CYC);
      ST_SPIN:  phase_len = CNT_W'(SPIN_CYC);
      default:  phase_len = {CNT_W{1'b0}};
    endcase
  endfunction

  // Timer starts at duration-1 so a phase lasts exactly its duration.
  function automatic logic [CNT_W-1:0] load_for(input wm_state_t s);
    if (is_running(s)) begin
      return phase_len(s) - CNT_W'(1);
    end else begin
      return {CNT_W{1'b0}};
    end
  endfunction

  function automatic wm_state_t phase_after(input wm_state_t s);
    case (s)
      ST_SOAK:  phase_after = ST_WASH;
      ST_WASH:  phase_after = ST_RINSE;
      ST_RINSE: phase_after = ST_SPIN;
      default:  phase_after = ST_IDLE;
    endcase
  endfunction

  assign prog_s = prog_select(mode_1, mode_2, mode_3);

  wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_value (tmr_val_s),
    .enable     (tmr_en_s),
    .count      (tmr_cnt_s),
    .zero       (tmr_zero_s)
  );

  assign time_left = tmr_cnt_s;

  // Next-state decode: cancel beats lid, lid beats expiry, expiry beats coin.
  always_comb begin
    state_s    = state_r;
    credit_s   = credit_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = {CNT_W{1'b0}};
    tmr_en_s   = 1'b0;
    coin_ret_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cancel) begin
          credit_s   = 4'd0;
          coin_ret_s = coin | (credit_r != 4'd0);
        end else if (coin) begin
          if ((credit_r + 4'd1) == PRICE_C) begin
            state_s  = ST_READY;
            credit_s = 4'd0;
          end else begin
            credit_s = credit_r + 4'd1;
          end
        end else begin
          credit_s = credit_r;
        end
      end
      ST_READY: begin
        if (cancel) begin
          state_s    = ST_IDLE;
          coin_ret_s = 1'b1;
        end else begin
          coin_ret_s = coin;
          if (!lid) begin
            case (prog_s)
              PROG_FULL:  state_s = ST_SOAK;
              PROG_WASH:  state_s = ST_WASH;
              PROG_RINSE: state_s = ST_RINSE;
              default:    state_s = ST_READY;
            endcase
            tmr_load_s = is_running(state_s);
            tmr_val_s  = load_for(state_s);
          end else begin
            state_s = ST_READY;
          end
        end
      end
      ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN: begin
        coin_ret_s = coin;
        if (cancel) begin
          state_s    = ST_IDLE;
          tmr_load_s = 1'b1;
        end else if (lid) begin
          state_s = state_r;
        end else if (tmr_zero_s) begin
          state_s    = phase_after(state_r);
          tmr_load_s = 1'b1;
          tmr_val_s  = load_for(state_s);
          done_s     = (state_r == ST_SPIN);
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        credit_s   = 4'd0;
        tmr_load_s = 1'b1;
      end
    endcase
  end

  // Water flows while the post-edge count is still within the fill window.
  always_comb begin
    if (tmr_load_s) begin
      cnt_next_s = tmr_val_s;
    end else if (tmr_en_s) begin
      cnt_next_s = tmr_cnt_s - CNT_W'(1);
    end else begin
      cnt_next_s = tmr_cnt_s;
    end
    run_next_s = is_running(state_s);
    if (run_next_s && (state_s != ST_SPIN) && !lid) begin
      water_s = (cnt_next_s >= (phase_len(state_s) - CNT_W'(FILL_CYC)));
    end else begin
      water_s = 1'b0;
    end
  end

  // State, credit and every indicator output are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      credit_r        <= 4'd0;
      idle            <= 1'b1;
      ready           <= 1'b0;
      soak_Operation  <= 1'b0;
      wash_Operation  <= 1'b0;
      rinse_Operation <= 1'b0;
      spin_Operation  <= 1'b0;
      water_Intake    <= 1'b0;
      coin_Return     <= 1'b0;
      paused          <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_r         <= state_s;
      credit_r        <= credit_s;
      idle            <= (state_s == ST_IDLE);
      ready           <= (state_s == ST_READY);
      soak_Operation  <= (state_s == ST_SOAK)  && !lid;
      wash_Operation  <= (state_s == ST_WASH)  && !lid;
      rinse_Operation <= (state_s == ST_RINSE) && !lid;
      spin_Operation  <= (state_s == ST_SPIN)  && !lid;
      water_Intake    <= water_s;
      coin_Return     <= coin_ret_s;
      paused          <= run_next_s && lid;
      done            <= done_s;
    end
  end

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Directed scenarios plus random traffic, compared cycle by cycle with a phase-queue model.
module tb_wm_cycle_sequencer;

  localparam int CNT_W = 16;
  localparam int FILL  = 2;
  localparam int PRICE = 2;

  logic clock = 1'b0;
  logic reset, lid, coin, cancel, mode_1, mode_2, mode_3;
  logic idle, ready, soak_Operation, wash_Operation, rinse_Operation, spin_Operation;
  logic water_Intake, coin_Return, paused, done;
  logic [CNT_W-1:0] time_left;

  int n_checks = 0;
  int n_errors = 0;

  // model: stage 0 idle, 1 ready, 2 running through a queue of phases (0 soak .. 3 spin)
  int dur [4] = '{4, 6, 3, 5};
  int q[$];
  int m_stage = 0, m_credit = 0, m_rem = 0;
  bit m_paused = 1'b0, m_ret = 1'b0, m_done = 1'b0;

  int n_soak, n_wash, n_rinse, n_spin, n_water, n_done, n_ret, n_run, n_paused;

  wm_cycle_sequencer #(
    .CNT_W(CNT_W), .SOAK_CYC(4), .WASH_CYC(6), .RINSE_CYC(3), .SPIN_CYC(5),
    .FILL_CYC(FILL), .COIN_PRICE(PRICE)
  ) dut (
    .clock(clock), .reset(reset), .lid(lid), .coin(coin), .cancel(cancel),
    .mode_1(mode_1), .mode_2(mode_2), .mode_3(mode_3),
    .idle(idle), .ready(ready), .soak_Operation(soak_Operation),
    .wash_Operation(wash_Operation), .rinse_Operation(rinse_Operation),
    .spin_Operation(spin_Operation), .water_Intake(water_Intake),
    .coin_Return(coin_Return), .paused(paused), .done(done), .time_left(time_left)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_acc();
    n_soak = 0; n_wash = 0; n_rinse = 0; n_spin = 0; n_water = 0;
    n_done = 0; n_ret = 0; n_run = 0; n_paused = 0;
  endtask

  task automatic model_update();
    m_ret  = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      m_stage = 0; m_credit = 0; m_rem = 0; m_paused = 1'b0; q.delete();
    end else if (m_stage == 0) begin
      if (cancel) begin
        m_ret = coin || (m_credit > 0);
        m_credit = 0;
      end else if (coin) begin
        m_credit++;
        if (m_credit == PRICE) begin m_stage = 1; m_credit = 0; end
      end
    end else if (m_stage == 1) begin
      if (cancel) begin
        m_stage = 0; m_ret = 1'b1;
      end else begin
        m_ret = coin;
        if (!lid && (mode_1 || mode_2 || mode_3)) begin
          if (mode_1) q = '{0, 1, 2, 3};
          else if (mode_2) q = '{1, 2, 3};
          else q = '{2, 3};
          m_rem = dur[q[0]];
          m_stage = 2;
        end
      end
    end else begin
      m_ret = coin;
      m_paused = 1'b0;
      if (cancel) begin
        m_stage = 0; q.delete();
      end else if (lid) begin
        m_paused = 1'b1;
      end else if (m_rem == 1) begin
        void'(q.pop_front());
        if (q.size() == 0) begin m_stage = 0; m_done = 1'b1; end
        else m_rem = dur[q[0]];
      end else begin
        m_rem--;
      end
    end
  endtask

  task automatic compare_all();
    int ph;
    bit run, act;
    int sum;
    run = (m_stage == 2);
    ph  = run ? q[0] : -1;
    act = run && !m_paused;
    check("idle",   idle,   m_stage == 0);
    check("ready",  ready,  m_stage == 1);
    check("soak",   soak_Operation,  act && ph == 0);
    check("wash",   wash_Operation,  act && ph == 1);
    check("rinse",  rinse_Operation, act && ph == 2);
    check("spin",   spin_Operation,  act && ph == 3);
    check("water",  water_Intake, act && ph != 3 && ((dur[ph < 0 ? 0 : ph] - m_rem) < FILL));
    check("paused", paused, run && m_paused);
    check("coin_return", coin_Return, m_ret);
    check("done",   done, m_done);
    check("time_left", time_left, run ? m_rem - 1 : 0);
    sum = int'(idle) + int'(ready) + int'(soak_Operation) + int'(wash_Operation)
        + int'(rinse_Operation) + int'(spin_Operation);
    check("onehot", sum, (run && m_paused) ? 0 : 1);
    n_soak += int'(soak_Operation);  n_wash += int'(wash_Operation);
    n_rinse += int'(rinse_Operation); n_spin += int'(spin_Operation);
    n_water += int'(water_Intake);   n_done += int'(done);
    n_ret += int'(coin_Return);      n_paused += int'(paused);
    n_run += int'(soak_Operation | wash_Operation | rinse_Operation | spin_Operation);
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic insert_coins(input int n);
    for (int i = 0; i < n; i++) begin
      coin = 1'b1; tick();
      coin = 1'b0; tick();
    end
  endtask

  task automatic start(input logic m1, input logic m2, input logic m3);
    mode_1 = m1; mode_2 = m2; mode_3 = m3;
    tick();
    mode_1 = 1'b0; mode_2 = 1'b0; mode_3 = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    bit seen = 1'b0;
    while (k < limit && !seen) begin
      tick();
      seen = (done === 1'b1);
      k++;
    end
    check("done_seen", seen, 1'b1);
  endtask

  initial begin
    int k;
    bit found;
    reset = 1'b1; lid = 1'b0; coin = 1'b0; cancel = 1'b0;
    mode_1 = 1'b0; mode_2 = 1'b0; mode_3 = 1'b0;
    clr_acc();
    tick(); tick();
    reset = 1'b0;
    tick();

    // full program
    clr_acc();
    insert_coins(2);
    check("armed", ready, 1'b1);
    start(1'b1, 1'b0, 1'b0);
    wait_done(60);
    check("full_soak_cycles", n_soak, 4);
    check("full_wash_cycles", n_wash, 6);
    check("full_rinse_cycles", n_rinse, 3);
    check("full_spin_cycles", n_spin, 5);
    check("full_water_cycles", n_water, 6);
    check("full_run_cycles", n_run, 18);
    check("full_done_pulses", n_done, 1);
    check("full_idle_with_done", idle, 1'b1);
    tick();
    check("done_one_cycle", done, 1'b0);

    // mode_1 beats mode_3, then cancel mid-run without refund
    insert_coins(2);
    start(1'b1, 1'b0, 1'b1);
    check("prio_soak", soak_Operation, 1'b1);
    check("prio_not_rinse", rinse_Operation, 1'b0);
    clr_acc();
    cancel = 1'b1; tick(); cancel = 1'b0; tick();
    check("run_cancel_idle", idle, 1'b1);
    check("run_cancel_no_refund", n_ret, 0);

    // rinse-only program
    clr_acc();
    insert_coins(2);
    start(1'b0, 1'b0, 1'b1);
    wait_done(40);
    check("rinse_only_soak", n_soak + n_wash, 0);
    check("rinse_only_rinse", n_rinse, 3);
    check("rinse_only_spin", n_spin, 5);
    check("rinse_only_water", n_water, 2);

    // lid opened during WASH at time_left 3
    clr_acc();
    insert_coins(2);
    start(1'b0, 1'b1, 1'b0);
    k = 0;
    while (!(wash_Operation === 1'b1 && time_left == 16'd3) && k < 20) begin
      tick(); k++;
    end
    found = (wash_Operation === 1'b1 && time_left == 16'd3);
    check("wash_tl3_reached", found, 1'b1);
    lid = 1'b1;
    repeat (7) begin
      tick();
      check("lid_paused", paused, 1'b1);
      check("lid_frozen", time_left, 3);
    end
    lid = 1'b0;
    wait_done(60);
    check("lid_wash_cycles", n_wash, 6);
    check("lid_paused_cycles", n_paused, 7);
    check("lid_water_cycles", n_water, 4);

    // refunds on cancel from IDLE with credit and from READY
    clr_acc();
    coin = 1'b1; tick(); coin = 1'b0; tick();
    cancel = 1'b1; tick(); cancel = 1'b0; tick(); tick();
    check("idle_cancel_refund", n_ret, 1);
    coin = 1'b1; tick(); coin = 1'b0; tick();
    check("credit_cleared", ready, 1'b0);
    cancel = 1'b1; tick(); cancel = 1'b0; tick();
    clr_acc();
    insert_coins(2);
    cancel = 1'b1; tick(); cancel = 1'b0; tick(); tick();
    check("ready_cancel_refund", n_ret, 1);
    check("ready_cancel_idle", idle, 1'b1);

    // coin during SPIN is returned and SPIN is unaffected
    insert_coins(2);
    start(1'b0, 1'b0, 1'b1);
    clr_acc();
    k = 0;
    while (spin_Operation !== 1'b1 && k < 20) begin tick(); k++; end
    check("spin_reached", spin_Operation, 1'b1);
    coin = 1'b1; tick(); coin = 1'b0;
    wait_done(20);
    check("spin_coin_refund", n_ret, 1);
    check("spin_cycles", n_spin, 5);

    // reset during RINSE
    insert_coins(2);
    start(1'b0, 1'b0, 1'b1);
    tick();
    clr_acc();
    reset = 1'b1; tick(); reset = 1'b0;
    check("reset_idle", idle, 1'b1);
    repeat (6) tick();
    check("reset_no_done", n_done, 0);
    check("reset_no_refund", n_ret, 0);

    // random traffic against the model
    repeat (600) begin
      reset  = ($urandom_range(0, 199) == 0);
      coin   = ($urandom_range(0, 3) == 0);
      cancel = ($urandom_range(0, 39) == 0);
      lid    = ($urandom_range(0, 9) == 0);
      mode_1 = ($urandom_range(0, 3) == 0);
      mode_2 = ($urandom_range(0, 3) == 0);
      mode_3 = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0; coin = 1'b0; cancel = 1'b0; lid = 1'b0;
    mode_1 = 1'b0; mode_2 = 1'b0; mode_3 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
